acc_ctrl: RTL

ACC_CTRL -- requirements
Module: acc_ctrl

---
 rtl/acc_ctrl_pkg.sv | 60 ++++++
 rtl/acc_decode.sv | 94 +++++++++
 rtl/acc_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/acc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// acc_ctrl_pkg
// Shared definitions for the accumulator controller slice:
//   - opcode_e   : instruction opcodes (instr[8:5])
//   - state_e    : controller FSM states
//   - next_e     : what the decoder says should follow the EXEC cycle
//   - strobe_t   : bundle of accumulator / register-file control strobes
//   - TIMEOUT_DEFAULT, IW_DEFAULT : default parameter values
// -----------------------------------------------------------------------------
package acc_ctrl_pkg;

  localparam int IW_DEFAULT      = 9;
  localparam int TIMEOUT_DEFAULT = 15;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDL  = 4'h1,
    OP_LDH  = 4'h2,
    OP_MVA  = 4'h3,
    OP_ALU  = 4'h4,
    OP_STA  = 4'h5,
    OP_CLR  = 4'h6,
    OP_LDM  = 4'h7,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEM_WAIT,
    ST_HALT,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    NX_FETCH,
    NX_MEM,
    NX_HALT,
    NX_ERR
  } next_e;

  typedef struct packed {
    logic       acc_we;
    logic       from_reg;
    logic       from_imm;
    logic       from_alu;
    logic       load_hi;
    logic       reg_we;
    logic [3:0] imm_out;
    logic [3:0] reg_addr;
    logic [2:0] alu_op;
  } strobe_t;

  // The three "working" states are the ones that report busy.
  function automatic logic is_busy_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_EXEC) || (s == ST_MEM_WAIT);
  endfunction

endpackage

// File: rtl/acc_decode.sv
// -----------------------------------------------------------------------------
// acc_decode
// Purely combinational instruction decoder: turns the instruction register
// into accumulator / register-file strobes for the EXEC cycle and reports
// which state the controller should move to afterwards.
//
// Ports:
//   en         in   1    decode enable (high only in EXEC); strobes are 0 when low
//   ir         in   IW   instruction register
//   strb       out  strobe_t  control strobes
//   next_kind  out  next_e    follow-on action (fetch / mem wait / halt / error)
// -----------------------------------------------------------------------------
module acc_decode
  import acc_ctrl_pkg::*;
#(
  parameter int IW = IW_DEFAULT
) (
  input  logic          en,
  input  logic [IW-1:0] ir,
  output strobe_t       strb,
  output next_e         next_kind
);

  logic [3:0] opcode;
  logic [4:0] operand;

  assign opcode  = ir[IW-1 -: 4];
  assign operand = ir[4:0];

  // Decode is computed unconditionally and then squashed when not in EXEC,
  // so no strobe can leak into other states.
  always_comb begin
    strb      = '0;
    next_kind = NX_ERR;

    case (opcode)
      OP_NOP: begin
        next_kind = NX_FETCH;
      end
      OP_LDL: begin
        next_kind     = NX_FETCH;
        strb.acc_we   = 1'b1;
        strb.from_imm = 1'b1;
        strb.imm_out  = operand[3:0];
      end
      OP_LDH: begin
        next_kind     = NX_FETCH;
        strb.acc_we   = 1'b1;
        strb.from_imm = 1'b1;
        strb.load_hi  = 1'b1;
        strb.imm_out  = operand[3:0];
      end
      OP_MVA: begin
        next_kind     = NX_FETCH;
        strb.acc_we   = 1'b1;
        strb.from_reg = 1'b1;
        strb.reg_addr = operand[3:0];
      end
      OP_ALU: begin
        // ALU form only has room for a 2-bit register index.
        next_kind     = NX_FETCH;
        strb.acc_we   = 1'b1;
        strb.from_alu = 1'b1;
        strb.alu_op   = operand[2:0];
        strb.reg_addr = {2'b00, operand[4:3]};
      end
      OP_STA: begin
        next_kind     = NX_FETCH;
        strb.reg_we   = 1'b1;
        strb.reg_addr = operand[3:0];
      end
      OP_CLR: begin
        // Writing with no source selected clears the accumulator.
        next_kind   = NX_FETCH;
        strb.acc_we = 1'b1;
      end
      OP_LDM: begin
        next_kind     = NX_MEM;
        strb.reg_addr = operand[3:0];
      end
      OP_HALT: begin
        next_kind = NX_HALT;
      end
      default: begin
        next_kind = NX_ERR;
      end
    endcase

    if (!en) begin
      strb = '0;
    end
  end

endmodule

// File: rtl/acc_ctrl.sv
// -----------------------------------------------------------------------------
// acc_ctrl
// Fetch/execute controller for a nibble-loading accumulator datapath.
// Holds the FSM, the instruction register and the memory wait counter;
// instruction decode lives in acc_decode.
//
// Ports:
//   clk, Reset          clock, synchronous active-high reset
//   start               leave IDLE (ignored elsewhere)
//   instr_valid, instr  instruction fetch handshake / data
//   instr_ready         controller accepts instr this cycle (FETCH)
//   pc_inc              one-cycle program counter advance
//   acc_we, from_reg, from_imm, from_alu, load_hi, imm_out
//                       accumulator write controls
//   reg_addr, reg_we    register file address / write (data = accumulator)
//   alu_op              ALU operation select
//   mem_req, mem_ack    data memory load handshake
//   mem_sel             routes memory data onto the accumulator register input
//   busy, halted, err   status flags (registered)
// -----------------------------------------------------------------------------
module acc_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int IW      = IW_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          start,
  input  logic          instr_valid,
  input  logic [IW-1:0] instr,
  output logic          instr_ready,
  output logic          pc_inc,
  output logic          acc_we,
  output logic          from_reg,
  output logic          from_imm,
  output logic          from_alu,
  output logic          load_hi,
  output logic [3:0]    imm_out,
  output logic [3:0]    reg_addr,
  output logic [2:0]    alu_op,
  output logic          reg_we,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic          mem_sel,
  output logic          busy,
  output logic          halted,
  output logic          err
);

  state_e        state;
  state_e        state_nxt;
  logic [IW-1:0] ir;
  logic [3:0]    wait_cnt;
  logic [3:0]    wait_nxt;

  strobe_t       dec_strb;
  next_e         dec_next;
  logic          exec_cycle;
  logic          in_mem_wait;
  logic          ack_now;
  logic          fetch_take;

  assign exec_cycle  = (state == ST_EXEC);
  assign in_mem_wait = (state == ST_MEM_WAIT);
  assign fetch_take  = (state == ST_FETCH) && instr_valid;
  assign ack_now     = in_mem_wait && mem_ack;

  acc_decode #(
    .IW (IW)
  ) u_decode (
    .en        (exec_cycle),
    .ir        (ir),
    .strb      (dec_strb),
    .next_kind (dec_next)
  );

  // Next-state and wait-counter logic. The counter reports the number of
  // MEM_WAIT cycles already spent without an ack; the timeout fires in the
  // cycle that would bring it to TIMEOUT, and an ack in that same cycle wins.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (instr_valid) begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (dec_next)
          NX_FETCH: state_nxt = ST_FETCH;
          NX_MEM: begin
            state_nxt = ST_MEM_WAIT;
            wait_nxt  = 4'd0;
          end
          NX_HALT:  state_nxt = ST_HALT;
          default:  state_nxt = ST_ERR;
        endcase
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          state_nxt = ST_FETCH;
          wait_nxt  = 4'd0;
        end else begin
          wait_nxt = wait_cnt + 4'd1;
          if (wait_cnt == 4'(TIMEOUT - 1)) begin
            state_nxt = ST_ERR;
          end
        end
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      ST_ERR: begin
        state_nxt = ST_ERR;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register, IR, wait counter and status flags. Flags are registered
  // from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      ir       <= '0;
      wait_cnt <= 4'd0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (fetch_take) begin
        ir <= instr;
      end
      busy   <= is_busy_state(state_nxt);
      halted <= (state_nxt == ST_HALT);
      err    <= (state_nxt == ST_ERR);
    end
  end

  // Output strobes. Decoder strobes are already zero outside EXEC; the memory
  // completion strobes are merged in during MEM_WAIT.
  assign instr_ready = (state == ST_FETCH);
  assign pc_inc      = fetch_take;
  assign acc_we      = dec_strb.acc_we | ack_now;
  assign from_reg    = dec_strb.from_reg | ack_now;
  assign from_imm    = dec_strb.from_imm;
  assign from_alu    = dec_strb.from_alu;
  assign load_hi     = dec_strb.load_hi;
  assign imm_out     = dec_strb.imm_out;
  assign alu_op      = dec_strb.alu_op;
  assign reg_we      = dec_strb.reg_we;
  assign reg_addr    = in_mem_wait ? ir[3:0] : dec_strb.reg_addr;
  assign mem_req     = in_mem_wait;
  assign mem_sel     = ack_now;

endmodule
